seg7_scan_driver: RTL and testbench

- Output-side counterpart to the board switch sampler: it drives the Nexys A7 eight-digit, common-anode, seven-segment display from a 32-bit value.
- The block multiplexes the digits with a refresh counter and decodes each 4-bit nibble to hex segments.
- It supports per-digit enable, per-digit decimal point and 16-level brightness.
- New data goes into a shadow register and is applied only at a frame boundary, so the display never tears.

---
 rtl/seg7_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Scans the eight common-anode seven-segment digits of a Nexys A7 board
//   from a 32-bit hex value, with per-digit enable, per-digit decimal point
//   and 16-level brightness. New data is held in a shadow register and is
//   copied to the displayed (active) set only at a frame boundary, so a
//   frame never shows a mix of old and new data.
//
// Parameters
//   SCAN_DIV  clock cycles per digit slot (a multiple of 16, >= 16)
//
// Ports
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   VALUE    value to show; digit i shows VALUE[4i+3:4i]
//   DP_IN    decimal points, bit i lights the DP of digit i
//   EN_IN    digit enables, bit i = 0 blanks digit i
//   BRIGHT   brightness 0 (dimmest lit) .. 15 (full), not shadowed
//   LOAD     one-cycle strobe capturing VALUE/DP_IN/EN_IN into the shadow
//   AN       digit anodes, active low
//   SEG      segment cathodes {CG..CA}, active low
//   DP       decimal-point cathode, active low
//   PENDING  shadow data waiting for a frame boundary
//   FRAME    one-cycle pulse after each frame boundary
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] VALUE,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  EN_IN,
  input  logic [3:0]  BRIGHT,
  input  logic        LOAD,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int unsigned SUB_LEN = SCAN_DIV / 16;
  localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

  logic [CNT_W-1:0] cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       sub;
  logic [2:0]       idx;
  logic             tick;
  logic             sub_step;
  logic             boundary;

  logic [31:0] shadow_val;
  logic [7:0]  shadow_dp;
  logic [7:0]  shadow_en;
  logic [31:0] active_val;
  logic [7:0]  active_dp;
  logic [7:0]  active_en;

  logic        lit;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (cnt == CNT_W'(SCAN_DIV - 1));
  assign sub_step = (sub_cnt == SUB_W'(SUB_LEN - 1));
  assign boundary = tick && (idx == 3'd7);

  // Subslot is tracked by a second counter that steps every SUB_LEN cycles
  // instead of dividing cnt; both are realigned at each slot tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      sub_cnt <= '0;
      sub     <= '0;
      idx     <= '0;
    end else if (tick) begin
      cnt     <= '0;
      sub_cnt <= '0;
      sub     <= '0;
      idx     <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (sub_step) begin
        sub_cnt <= '0;
        sub     <= sub + 4'd1;
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  // A LOAD on the boundary cycle bypasses the shadow and goes straight to
  // the active set, so PENDING never rises for it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_en  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      active_en  <= '0;
      PENDING    <= 1'b0;
      FRAME      <= 1'b0;
    end else begin
      FRAME <= boundary;
      if (boundary) begin
        if (LOAD) begin
          active_val <= VALUE;
          active_dp  <= DP_IN;
          active_en  <= EN_IN;
        end else if (PENDING) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
          active_en  <= shadow_en;
        end
        PENDING <= 1'b0;
      end else if (LOAD) begin
        shadow_val <= VALUE;
        shadow_dp  <= DP_IN;
        shadow_en  <= EN_IN;
        PENDING    <= 1'b1;
      end
    end
  end

  always_comb begin
    lit    = active_en[idx] && (sub <= BRIGHT);
    nibble = active_val[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN  <= '1;
      SEG <= '1;
      DP  <= 1'b1;
    end else if (lit) begin
      AN  <= ~(8'h01 << idx);
      SEG <= hex7(nibble);
      DP  <= ~active_dp[idx];
    end else begin
      AN  <= '1;
      SEG <= '1;
      DP  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with SCAN_DIV = 32.
// A cycle-count reference model predicts every output cycle from the
// display rules and queues the prediction; a monitor on the falling edge
// pops and compares against the DUT.
module tb_seg7_scan_driver;

  localparam int unsigned SD    = 32;
  localparam int unsigned FRAME_LEN = 8 * SD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] VALUE = '0;
  logic [7:0]  DP_IN = '0;
  logic [7:0]  EN_IN = '0;
  logic [3:0]  BRIGHT = 4'hF;
  logic        LOAD = 1'b0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        PENDING;
  logic        FRAME;

  seg7_scan_driver #(.SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .DP_IN(DP_IN), .EN_IN(EN_IN),
    .BRIGHT(BRIGHT), .LOAD(LOAD), .AN(AN), .SEG(SEG), .DP(DP),
    .PENDING(PENDING), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       frame;
  } obs_t;

  obs_t exp_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: t counts clock edges since reset release.
  int unsigned t = 0;
  logic [31:0] m_val = '0, s_val = '0;
  logic [7:0]  m_dp = '0, m_en = '0, s_dp = '0, s_en = '0;
  logic        m_pend = 1'b0;
  int unsigned pos, dig;
  logic        lit_m, bnd;
  obs_t        e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t = 0;
      m_val = '0; m_dp = '0; m_en = '0;
      s_val = '0; s_dp = '0; s_en = '0;
      m_pend = 1'b0;
      exp_q.delete();
    end else begin
      pos = t % SD;
      dig = (t / SD) % 8;
      lit_m = m_en[dig] && ((pos / (SD / 16)) <= BRIGHT);
      e.an  = 8'hFF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      if (lit_m) begin
        e.an[dig] = 1'b0;
        e.seg = hex_tab[m_val[4*dig +: 4]];
        e.dp  = ~m_dp[dig];
      end
      bnd = ((t % FRAME_LEN) == FRAME_LEN - 1);
      e.frame = bnd;
      if (bnd) begin
        if (LOAD) begin
          m_val = VALUE; m_dp = DP_IN; m_en = EN_IN;
        end else if (m_pend) begin
          m_val = s_val; m_dp = s_dp; m_en = s_en;
        end
        m_pend = 1'b0;
      end else if (LOAD) begin
        s_val = VALUE; s_dp = DP_IN; s_en = EN_IN;
        m_pend = 1'b1;
      end
      e.pend = m_pend;
      exp_q.push_back(e);
      t++;
    end
  end

  obs_t got, want;
  always @(negedge CLK) begin
    got = {AN, SEG, DP, PENDING, FRAME};
    if (!RST_N) begin
      exp_q.delete();
      chk("reset_blank", 32'(got), 32'({8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    end else if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      chk("scan_out", 32'(got), 32'(want));
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] en);
    VALUE = v; DP_IN = d; EN_IN = en; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    VALUE = $urandom; DP_IN = 8'($urandom); EN_IN = 8'($urandom);
  endtask

  // Advance until the next model edge falls at frame phase p.
  task automatic wait_phase(input int unsigned p);
    for (int unsigned i = 0; i < 2 * FRAME_LEN; i++) begin
      if ((t % FRAME_LEN) == p) break;
      step();
    end
    chk("phase_reach", t % FRAME_LEN, p);
  endtask

  initial begin
    #1 RST_N = 1'b0;
    // Reset held for 5 cycles, then a full blank frame with no LOAD.
    steps(5);
    RST_N = 1'b1;
    steps(FRAME_LEN + 40);

    // Basic decode, full brightness.
    BRIGHT = 4'hF;
    wait_phase(30);
    do_load(32'h0123ABCD, 8'h00, 8'hFF);
    steps(3 * FRAME_LEN);

    // Enable mask and decimal point.
    wait_phase(100);
    do_load($urandom, 8'h01, 8'h0F);
    steps(2 * FRAME_LEN);

    // Brightness levels with all digits enabled.
    do_load($urandom, 8'($urandom), 8'hFF);
    BRIGHT = 4'h0;
    steps(2 * FRAME_LEN);
    BRIGHT = 4'h7;
    steps(2 * FRAME_LEN);
    BRIGHT = 4'hF;

    // Shadow: two mid-frame loads, last wins; then a load on the boundary.
    wait_phase(50);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    steps(40);
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    steps(FRAME_LEN);
    wait_phase(FRAME_LEN - 1);
    do_load(32'h3333_3333, 8'h00, 8'hFF);
    steps(FRAME_LEN + 20);

    // Async reset during digit 5 with data pending.
    wait_phase(20);
    do_load($urandom, 8'($urandom), 8'hFF);
    wait_phase(5 * SD + 10);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_blank", 32'({AN, SEG, DP}), 32'({8'hFF, 7'h7F, 1'b1}));
    chk("async_pending", 32'(PENDING), 32'd0);
    steps(3);
    RST_N = 1'b1;
    do_load(32'hFEDC_BA98, 8'hA5, 8'hFF);
    steps(2 * FRAME_LEN);

    // Randomized loads, enables, decimal points and brightness.
    for (int unsigned k = 0; k < 30; k++) begin
      BRIGHT = 4'($urandom);
      steps($urandom_range(0, 300));
      if ($urandom_range(0, 3) == 0) wait_phase(FRAME_LEN - 1);
      do_load($urandom, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        steps($urandom_range(1, 200));
        do_load($urandom, 8'($urandom), 8'($urandom));
      end
      steps($urandom_range(10, 150));
      BRIGHT = 4'($urandom);
    end
    steps(FRAME_LEN + 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
